// File: rtl/split_scan_pkg.sv
// Shared types and LFSR helpers for the split checker scan sequencer.
package split_scan_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} scan_state_t;

  localparam int MAX_CAND_W = 185;

  localparam logic [MAX_CAND_W-1:0] TAP_MASK_185 = (MAX_CAND_W'(1) << 184) | (MAX_CAND_W'(1) << 160);
  localparam logic [MAX_CAND_W-1:0] TAP_MASK_16  = MAX_CAND_W'(16'hB400);

  // Unsupported widths fall back to a single top tap so the LFSR still cycles.
  function automatic logic [MAX_CAND_W-1:0] tap_mask(input int width);
    case (width)
      185:     tap_mask = TAP_MASK_185;
      16:      tap_mask = TAP_MASK_16;
      default: tap_mask = MAX_CAND_W'(1) << (width - 1);
    endcase
  endfunction

  function automatic logic [MAX_CAND_W-1:0] lfsr_next(input logic [MAX_CAND_W-1:0] cur,
                                                     input logic [MAX_CAND_W-1:0] mask);
    lfsr_next = (cur >> 1) ^ (cur[0] ? mask : '0);
  endfunction

endpackage

// File: rtl/split_scan_lfsr.sv
// Candidate register: loads a nonzero seed, steps a Galois LFSR, or holds.
module split_scan_lfsr
  import split_scan_pkg::*;
#(
  parameter int CAND_W = 185
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [CAND_W-1:0] seed,
  output logic [CAND_W-1:0] cand
);

  localparam logic [MAX_CAND_W-1:0] TAP_FULL = tap_mask(CAND_W);

  logic [CAND_W-1:0]     cand_q, cand_d;
  logic [MAX_CAND_W-1:0] cand_ext;

  always_comb begin
    cand_ext = MAX_CAND_W'(cand_q);
    cand_d   = cand_q;
    if (load)
      cand_d = (seed == '0) ? CAND_W'(1) : seed;
    else if (step)
      cand_d = CAND_W'(lfsr_next(cand_ext, TAP_FULL));
  end

  always_ff @(posedge clk) begin
    if (rst)
      cand_q <= '0;
    else
      cand_q <= cand_d;
  end

  assign cand = cand_q;

endmodule

// File: rtl/split_scan_ctrl.sv
// Scan sequencer: walks LFSR candidates until all split checkers accept, the try
// budget runs out, or abort. Define SPLIT_SCAN_STATS_EN to add per-split fail counters.
module split_scan_ctrl
  import split_scan_pkg::*;
#(
  parameter int NUM_SPLITS = 4,
  parameter int CAND_W     = 185,
  parameter int MAX_TRIES  = 1024,
  parameter int TRY_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CAND_W-1:0]     seed,
  input  logic                  abort,
  output logic [CAND_W-1:0]     cand,
  input  logic [NUM_SPLITS-1:0] split_ok,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  found,
  output logic [CAND_W-1:0]     solution,
`ifdef SPLIT_SCAN_STATS_EN
  output logic [NUM_SPLITS-1:0][TRY_W-1:0] fail_cnt,
`endif
  output logic [TRY_W-1:0]      tries
);

  scan_state_t       state_q, state_d;
  logic [CAND_W-1:0] seed_q, seed_d;
  logic [CAND_W-1:0] solution_q, solution_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              found_q, found_d;
  logic              lfsr_load, lfsr_step;
  logic              hit;

  assign hit = &split_ok;

  split_scan_lfsr #(.CAND_W(CAND_W)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .step (lfsr_step),
    .seed (seed_q),
    .cand (cand)
  );

  // Termination priority in EVAL: abort, then hit, then budget exhaustion.
  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    solution_d = solution_q;
    tries_d    = tries_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    found_d    = found_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          seed_d  = seed;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        lfsr_load  = 1'b1;
        tries_d    = '0;
        found_d    = 1'b0;
        solution_d = '0;
        state_d    = EVAL;
      end
      EVAL: begin
        if (abort || hit || tries_q == TRY_W'(MAX_TRIES - 1)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
        if (abort) begin
          found_d = 1'b0;
        end else if (hit) begin
          solution_d = cand;
          found_d    = 1'b1;
        end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
          tries_d = TRY_W'(MAX_TRIES);
        end else begin
          lfsr_step = 1'b1;
          tries_d   = tries_q + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      seed_q     <= '0;
      solution_q <= '0;
      tries_q    <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      solution_q <= solution_d;
      tries_q    <= tries_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      found_q    <= found_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign found        = found_q;
  assign solution     = solution_q;
  assign tries        = tries_q;

`ifdef SPLIT_SCAN_STATS_EN
  logic [NUM_SPLITS-1:0][TRY_W-1:0] fail_cnt_q, fail_cnt_d;

  // A cycle that ends on abort is not counted as a checked candidate.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (state_q == LOAD) begin
      fail_cnt_d = '0;
    end else if (state_q == EVAL && !abort) begin
      for (int i = 0; i < NUM_SPLITS; i++)
        if (!split_ok[i])
          fail_cnt_d[i] = fail_cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      fail_cnt_q <= '0;
    else
      fail_cnt_q <= fail_cnt_d;
  end

  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_split_scan_ctrl.sv
// Directed, table-driven bench for split_scan_ctrl with a 16-bit candidate and an 8-try budget.
module tb_split_scan_ctrl;

  localparam int CW = 16;
  localparam int NS = 4;
  localparam int MT = 8;
  localparam int TW = 4;

  typedef enum int {M_ONES, M_ZERO, M_MATCH, M_SPLIT1} chk_mode_t;

  typedef struct {
    logic [CW-1:0] seed;
    chk_mode_t     mode;
    logic [CW-1:0] target;
    logic          exp_found;
    logic [CW-1:0] exp_solution;
    logic [TW-1:0] exp_tries;
    logic [CW-1:0] exp_cand;
    int            exp_latency;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, abort, result_ready;
  logic [CW-1:0] seed, cand, solution;
  logic [NS-1:0] split_ok;
  logic          busy, result_valid, found;
  logic [TW-1:0] tries;
`ifdef SPLIT_SCAN_STATS_EN
  logic [NS-1:0][TW-1:0] fail_cnt;
`endif

  int            errors = 0;
  int            checks = 0;
  chk_mode_t     mode   = M_ONES;
  logic [CW-1:0] target = '0;
  vec_t          vecs[5];

  split_scan_ctrl #(
    .NUM_SPLITS (NS),
    .CAND_W     (CW),
    .MAX_TRIES  (MT),
    .TRY_W      (TW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .seed         (seed),
    .abort        (abort),
    .cand         (cand),
    .split_ok     (split_ok),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .found        (found),
    .solution     (solution),
`ifdef SPLIT_SCAN_STATS_EN
    .fail_cnt     (fail_cnt),
`endif
    .tries        (tries)
  );

  always #5 clk = ~clk;

  // Checker bank model: combinational on the current candidate.
  always_comb begin
    split_ok = '0;
    case (mode)
      M_ONES:   split_ok = '1;
      M_ZERO:   split_ok = '0;
      M_MATCH:  split_ok = (cand == target) ? '1 : '0;
      M_SPLIT1: split_ok = {2'b11, (cand == target), 1'b1};
      default:  split_ok = '0;
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pulses start for one cycle and counts edges until result_valid, bounded.
  task automatic applyStimulus(input logic [CW-1:0] s, input chk_mode_t m, input logic [CW-1:0] t,
                               output int latency);
    mode    = m;
    target  = t;
    seed    = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    latency = 1;
    while (!result_valid && latency < 40) begin
      tick();
      latency++;
    end
  endtask

  task automatic completeHandshake(input string name);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    checkOutput({name, "_idle_valid"}, 32'(result_valid), 32'd0);
    checkOutput({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int n;

    // seed, mode, target, found, solution, tries, cand, latency
    vecs[0] = '{16'h00A5, M_ONES,  16'h0000, 1'b1, 16'h00A5, 4'd0, 16'h00A5, 3};
    vecs[1] = '{16'h00A5, M_ZERO,  16'h0000, 1'b0, 16'h0000, 4'd8, 16'h5391, 10};
    vecs[2] = '{16'h0000, M_MATCH, 16'h1680, 1'b1, 16'h1680, 4'd4, 16'h1680, 7};
    vecs[3] = '{16'h2D00, M_MATCH, 16'h0B40, 1'b1, 16'h0B40, 4'd2, 16'h0B40, 5};
    vecs[4] = '{16'h0001, M_MATCH, 16'h02D0, 1'b1, 16'h02D0, 4'd7, 16'h02D0, 10};

    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b0;
    seed         = '0;
    tick();
    tick();
    checkOutput("rst_cand", 32'(cand), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(result_valid), 32'd0);
    checkOutput("rst_found", 32'(found), 32'd0);
    checkOutput("rst_solution", 32'(solution), 32'd0);
    checkOutput("rst_tries", 32'(tries), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].seed, vecs[i].mode, vecs[i].target, lat);
      checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_latency));
      checkOutput($sformatf("v%0d_found", i), 32'(found), 32'(vecs[i].exp_found));
      checkOutput($sformatf("v%0d_solution", i), 32'(solution), 32'(vecs[i].exp_solution));
      checkOutput($sformatf("v%0d_tries", i), 32'(tries), 32'(vecs[i].exp_tries));
      checkOutput($sformatf("v%0d_cand", i), 32'(cand), 32'(vecs[i].exp_cand));
      checkOutput($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      completeHandshake($sformatf("v%0d", i));
    end

    // Result held while consumer stalls; start pulses in DONE are dropped.
    applyStimulus(16'h00A5, M_ONES, 16'h0000, lat);
    for (int c = 0; c < 5; c++) begin
      start = (c % 2 == 0);
      seed  = 16'h1234;
      tick();
      checkOutput($sformatf("hold%0d_valid", c), 32'(result_valid), 32'd1);
      checkOutput($sformatf("hold%0d_solution", c), 32'(solution), 32'h00A5);
      checkOutput($sformatf("hold%0d_cand", c), 32'(cand), 32'h00A5);
      checkOutput($sformatf("hold%0d_tries", c), 32'(tries), 32'd0);
    end
    start = 1'b0;
    completeHandshake("hold");
    tick();
    checkOutput("hold_start_not_queued", 32'(busy), 32'd0);

    // Abort on the same cycle the checkers accept candidate index 2.
    mode   = M_MATCH;
    target = 16'h5A00;
    seed   = 16'h0001;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n      = 0;
    while (!(busy && cand == 16'h5A00) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("abort_reach_timeout", 32'(n < 20), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_valid", 32'(result_valid), 32'd1);
    checkOutput("abort_found", 32'(found), 32'd0);
    checkOutput("abort_solution", 32'(solution), 32'd0);
    checkOutput("abort_tries", 32'(tries), 32'd2);
    completeHandshake("abort");

    // Reset in the middle of EVAL.
    mode  = M_ZERO;
    seed  = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("midrst_cand", 32'(cand), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_valid", 32'(result_valid), 32'd0);
    checkOutput("midrst_found", 32'(found), 32'd0);
    checkOutput("midrst_tries", 32'(tries), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("midrst_idle_busy", 32'(busy), 32'd0);

`ifdef SPLIT_SCAN_STATS_EN
    applyStimulus(16'h0001, M_SPLIT1, 16'h2D00, lat);
    checkOutput("stats_found", 32'(found), 32'd1);
    checkOutput("stats_tries", 32'(tries), 32'd3);
    checkOutput("stats_fail1", 32'(fail_cnt[1]), 32'd3);
    checkOutput("stats_fail0", 32'(fail_cnt[0]), 32'd0);
    checkOutput("stats_fail2", 32'(fail_cnt[2]), 32'd0);
    completeHandshake("stats");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
